// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Read misses fetch a whole line from memory as an in-order burst before answering the CPU.
module cache_ctrl #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = AW - OB - IB;

  // state  | meaning
  // IDLE   | waiting for cpu_req; request registers loaded on accept
  // LOOKUP | tag compare; write-through, read hit, or refill launch
  // REFILL | mem_rd held, capturing beats in order
  // RESP   | refilled line resident; return the requested word
  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

  state_t          state;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [LINES-1:0] valid;
  logic [TW-1:0]   tags [LINES];
  logic [DW-1:0]   data [LINES*WORDS];
  logic [OB-1:0]   cnt;

  logic [OB-1:0]   off;
  logic [IB-1:0]   idx;
  logic [TW-1:0]   tag;
  logic            hit;

  assign off = req_addr[OB-1:0];
  assign idx = req_addr[OB+IB-1:OB];
  assign tag = req_addr[AW-1:OB+IB];
  assign hit = valid[idx] && (tags[idx] == tag);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      valid     <= '0;
      cnt       <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (req_we) begin
            mem_we    <= 1'b1;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            cpu_ready <= 1'b1;
            state     <= IDLE;
          end else if (hit) begin
            cpu_rdata <= data[{idx, off}];
            cpu_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            // Line stays invalid until the last beat lands, so an abort leaves no stale hit.
            valid[idx] <= 1'b0;
            mem_rd     <= 1'b1;
            mem_addr   <= {req_addr[AW-1:OB], {OB{1'b0}}};
            cnt        <= '0;
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
              valid[idx] <= 1'b1;
              tags[idx]  <= tag;
              mem_rd     <= 1'b0;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          cpu_rdata <= data[{idx, off}];
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data array kept free of reset so it can map onto a plain RAM.
  always_ff @(posedge clk) begin
    if (rst && state == LOOKUP && req_we && hit)
      data[{idx, off}] <= req_wdata;
    else if (rst && state == REFILL && mem_rvalid)
      data[{idx, cnt}] <= mem_rdata;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: memory responder with gaps and stray beats,
// transaction-level cache/memory model, and a per-cycle compare process.
module tb_cache_ctrl;

  localparam int WORDS = 4;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_rd;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  cache_ctrl #(.AW(32), .DW(32), .LINES(8), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory seen by the responder, and the model's view of memory
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  // model of which lines are resident
  bit          m_valid [8];
  int          m_tag   [8];

  bit gaps_en  = 0;
  bit stray_en = 0;
  int gap_cnt;
  int beats_sent;

  // transaction context shared with the compare process
  bit          active = 0;
  bit          t_we, t_miss, t_abort;
  logic [31:0] t_addr, t_wdata, exp_rdata;
  int          lat, ready_cnt, we_cnt, rd_cnt, ready_lat;
  bit          ready_seen;
  logic [31:0] last_rdata, last_rd_addr, last_we_addr, last_we_data;

  // memory responder
  initial begin
    int beat;
    int a;
    beat = 0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
      if (mem_rd && beat < WORDS) begin
        if (gaps_en && $urandom_range(0, 2) == 0) begin
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
          gap_cnt++;
        end else begin
          a = (int'(mem_addr[7:0]) + beat) % 256;
          mem_rvalid = 1'b1;
          mem_rdata  = mem[a];
          beat++;
          beats_sent = beat;
        end
      end else begin
        if (!mem_rd) beat = 0;
        mem_rvalid = stray_en && !mem_rd && ($urandom_range(0, 3) == 0);
        mem_rdata  = $urandom;
      end
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    if (!active) begin
      chk("idle_quiet", {29'b0, cpu_ready, mem_we, mem_rd}, 32'd0);
    end else begin
      if (cpu_ready) begin
        ready_cnt++;
        ready_seen = 1;
        ready_lat  = lat;
        last_rdata = cpu_rdata;
        if (!t_we) chk("cpu_rdata", cpu_rdata, exp_rdata);
        chk("ready_latency", lat, t_miss ? WORDS + 3 + gap_cnt : 2);
      end
      if (mem_we) begin
        we_cnt++;
        last_we_addr = mem_addr;
        last_we_data = mem_wdata;
        chk("mem_we_addr", mem_addr, t_addr);
        chk("mem_we_data", mem_wdata, t_wdata);
      end
      if (mem_rd) begin
        rd_cnt++;
        last_rd_addr = mem_addr;
        chk("mem_rd_addr", mem_addr, t_addr & ~32'd3);
      end
      lat++;
    end
  end

  task automatic start_txn(input bit we, input int addr, input logic [31:0] wdata);
    int idx, tg;
    idx = (addr / WORDS) % 8;
    tg  = addr / (WORDS * 8);
    t_we      = we;
    t_addr    = addr;
    t_wdata   = wdata;
    t_miss    = !we && !(m_valid[idx] && m_tag[idx] == tg);
    t_abort   = 0;
    exp_rdata = ref_mem[addr];
    lat = 0; ready_cnt = 0; we_cnt = 0; rd_cnt = 0; ready_lat = -1;
    ready_seen = 0; gap_cnt = 0; beats_sent = 0;
    @(posedge clk); #2;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    active    = 1;
  endtask

  task automatic do_txn(input bit we, input int addr, input logic [31:0] wdata);
    int i;
    int idx, tg;
    start_txn(we, addr, wdata);
    i = 0;
    while (!ready_seen && i < 100) begin
      @(negedge clk); #1;
      i++;
    end
    if (!ready_seen) chk("ready_timeout", 32'd0, 32'd1);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("ready_count", ready_cnt, 1);
    chk("mem_we_count", we_cnt, {31'b0, we});
    chk("mem_rd_cycles", rd_cnt, t_miss ? WORDS + gap_cnt : 0);
    active = 0;
    idx = (addr / WORDS) % 8;
    tg  = addr / (WORDS * 8);
    if (we) ref_mem[addr] = wdata;
    if (t_miss) begin
      m_valid[idx] = 1;
      m_tag[idx]   = tg;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    for (int k = 0; k < 8; k++) m_valid[k] = 0;
  endtask

  initial begin
    int addr;
    bit we;
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int k = 0; k < 256; k++) begin
      mem[k]     = k;
      ref_mem[k] = k;
    end
    for (int k = 0; k < 8; k++) begin
      m_valid[k] = 0;
      m_tag[k]   = 0;
    end
    @(negedge clk);
    chk("rst_cpu_ready", {31'b0, cpu_ready}, 0);
    chk("rst_mem_rd",    {31'b0, mem_rd}, 0);
    chk("rst_mem_we",    {31'b0, mem_we}, 0);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    apply_reset();

    // 1: cold read miss
    do_txn(0, 'h05, 0);
    chk("t1_rdata", last_rdata, 32'h5);
    chk("t1_line_addr", last_rd_addr, 32'h4);
    chk("t1_rd_cycles", rd_cnt, 4);
    // 2: hit in same line
    do_txn(0, 'h06, 0);
    chk("t2_rdata", last_rdata, 32'h6);
    chk("t2_no_refill", rd_cnt, 0);
    chk("t2_latency", ready_lat, 2);
    // 3: write hit, then read back
    do_txn(1, 'h06, 32'hAB);
    chk("t3_we_addr", last_we_addr, 32'h6);
    chk("t3_we_data", last_we_data, 32'hAB);
    do_txn(0, 'h06, 0);
    chk("t3_readback", last_rdata, 32'hAB);
    chk("t3_hit", rd_cnt, 0);
    // 4: write miss does not allocate
    do_txn(1, 'h40, 32'h11);
    chk("t4_we_addr", last_we_addr, 32'h40);
    do_txn(0, 'h40, 0);
    chk("t4_refill", last_rd_addr, 32'h40);
    chk("t4_rdata", last_rdata, 32'h11);
    // 5: conflict on index 1
    do_txn(0, 'h05, 0);
    do_txn(0, 'h25, 0);
    chk("t5_line_addr", last_rd_addr, 32'h24);
    chk("t5_rdata", last_rdata, 32'h25);
    do_txn(0, 'h05, 0);
    chk("t5_remiss", rd_cnt, 4);
    chk("t5_rdata2", last_rdata, 32'h5);

    // 6: reset in the middle of a refill
    start_txn(0, 'h85, 0);
    t_abort = 1;
    for (int i = 0; i < 50 && beats_sent < 3; i++) begin
      @(negedge clk); #1;
    end
    chk("t6_beats_reached", {31'b0, beats_sent >= 3}, 1);
    rst = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t6_mem_rd_dropped", {31'b0, mem_rd}, 0);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("t6_no_ready", ready_cnt, 0);
    chk("t6_no_we", we_cnt, 0);
    active = 0;
    for (int k = 0; k < 8; k++) m_valid[k] = 0;
    do_txn(0, 'h85, 0);
    chk("t6_remiss", rd_cnt, 4);
    chk("t6_rdata", last_rdata, 32'h85);

    // randomized traffic with beat gaps and stray rvalid
    gaps_en  = 1;
    stray_en = 1;
    for (int n = 0; n < 300; n++) begin
      addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 63);
      we   = ($urandom_range(0, 9) < 3);
      do_txn(we, addr, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
